// File: rtl/tx_word_serializer_if.sv
// Bus between the FIR result path / UART Tx unit and the word serializer.
// The serializer takes the slave modport; the environment takes master.
`timescale 1ns/1ps
interface tx_word_serializer_if #(
    parameter int WORD_WIDTH = 16,
    parameter int UART_BITS  = 8,
    parameter int DEPTH      = 8
);
    localparam int AW = $clog2(DEPTH);

    logic [WORD_WIDTH-1:0] word_in;
    logic                  word_valid;
    logic                  tx_busy;
    logic                  tx_start;
    logic [UART_BITS-1:0]  tx_data;
    logic                  full;
    logic                  empty;
    logic [AW:0]           level;
    logic                  overflow;

    modport master (
        output word_in, word_valid, tx_busy,
        input  tx_start, tx_data, full, empty, level, overflow
    );

    modport slave (
        input  word_in, word_valid, tx_busy,
        output tx_start, tx_data, full, empty, level, overflow
    );
endinterface

// File: rtl/tx_word_serializer.sv
// Buffers result words in a FIFO and hands them to the UART Tx unit one byte
// at a time, MSB byte first, using the Tx start/busy handshake.
`timescale 1ns/1ps
module tx_word_serializer #(
    parameter int WORD_WIDTH = 16,
    parameter int UART_BITS  = 8,
    parameter int DEPTH      = 8
) (
    input  logic               clk,
    input  logic               rst,
    tx_word_serializer_if.slave bus
);
    localparam int BPW = WORD_WIDTH / UART_BITS;
    localparam int AW  = $clog2(DEPTH);
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [AW:0]    DEPTH_L   = (AW+1)'(DEPTH);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

    typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_e;

    state_e                state_q, state_d;
    logic [WORD_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           level_q, level_d;
    logic [WORD_WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]        byte_cnt_q, byte_cnt_d;
    logic                  overflow_q;
    logic                  tx_start;
    logic                  pop;
    logic                  push;

    // Pops only happen in IDLE, which frees a slot for a simultaneous write.
    assign pop  = (state_q == IDLE) && (level_q != '0);
    assign push = bus.word_valid && ((level_q != DEPTH_L) || pop);

    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + (AW+1)'(1);
        end else if (pop && !push) begin
            level_d = level_q - (AW+1)'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        tx_start   = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    shreg_d    = mem_q[rd_ptr_q];
                    byte_cnt_d = '0;
                    state_d    = START;
                end
            end
            START: begin
                if (!bus.tx_busy) begin
                    tx_start = 1'b1;
                    state_d  = WAIT_HI;
                end
            end
            WAIT_HI: begin
                if (bus.tx_busy) begin
                    state_d = WAIT_LO;
                end
            end
            WAIT_LO: begin
                if (!bus.tx_busy) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = IDLE;
                    end else begin
                        shreg_d    = shreg_q << UART_BITS;
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                        state_d    = START;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            overflow_q <= bus.word_valid && !push;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // Storage needs no reset; pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_q[wr_ptr_q] <= bus.word_in;
        end
    end

    assign bus.tx_start = tx_start;
    assign bus.tx_data  = shreg_q[WORD_WIDTH-1 -: UART_BITS];
    assign bus.level    = level_q;
    assign bus.full     = (level_q == DEPTH_L);
    assign bus.empty    = (level_q == '0);
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_tx_word_serializer.sv
// Directed bench for tx_word_serializer: a per-cycle vector table plus
// hand-written sequences for overflow, push-at-full, reset and stalled busy.
`timescale 1ns/1ps
module tb_tx_word_serializer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tx_word_serializer_if #(.WORD_WIDTH(16), .UART_BITS(8), .DEPTH(8)) bus ();

    tx_word_serializer #(.WORD_WIDTH(16), .UART_BITS(8), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Tx unit model: busy for 10 cycles after each accepted start strobe
    logic busy_drv  = 1'b0;
    logic use_model = 1'b0;
    int   model_cnt = 0;
    logic model_busy;
    always @(posedge clk) begin
        if (bus.tx_start === 1'b1) model_cnt <= 10;
        else if (model_cnt != 0)   model_cnt <= model_cnt - 1;
    end
    assign model_busy  = (model_cnt != 0);
    assign bus.tx_busy = use_model ? model_busy : busy_drv;

    logic [7:0] cap[$];
    logic [7:0] exp_q[$];
    always @(negedge clk) begin
        #2;
        if (bus.tx_start === 1'b1) cap.push_back(bus.tx_data);
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [15:0] w, input logic b);
        @(negedge clk);
        rst            = r;
        bus.word_valid = v;
        bus.word_in    = w;
        busy_drv       = b;
        #1;
    endtask

    task automatic idle(input int k);
        repeat (k) drive(1'b0, 1'b0, 16'h0000, busy_drv);
    endtask

    task automatic reset_dut();
        use_model = 1'b0;
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        cap.delete();
    endtask

    task automatic expect_bytes(input string name, input int budget);
        int n = 0;
        while (cap.size() < exp_q.size() && n < budget) begin
            idle(1);
            n++;
        end
        idle(30);
        check({name, "_count"}, cap.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
            check($sformatf("%s_byte%0d", name, i), {24'h0, cap[i]}, {24'h0, exp_q[i]});
    endtask

    typedef struct {
        logic        r, wv;
        logic [15:0] wi;
        logic        b;
        logic        st;
        logic [7:0]  d;
        logic [3:0]  l;
        logic        e, f, o;
    } vec_t;

    function automatic vec_t mk(logic r, logic wv, logic [15:0] wi, logic b, logic st,
                                logic [7:0] d, logic [3:0] l, logic e, logic f, logic o);
        vec_t v;
        v.r = r; v.wv = wv; v.wi = wi; v.b = b; v.st = st;
        v.d = d; v.l = l; v.e = e; v.f = f; v.o = o;
        return v;
    endfunction

    vec_t tbl[23];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // inputs (rst, valid, word, busy) | outputs seen in the same cycle
        tbl[0]  = mk(0, 1, 16'hA55A, 0, 0, 8'h00, 0, 1, 0, 0);
        tbl[1]  = mk(0, 0, 16'h0000, 0, 0, 8'h00, 1, 0, 0, 0);
        tbl[2]  = mk(0, 0, 16'h0000, 0, 1, 8'hA5, 0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 16'h0000, 1, 0, 8'hA5, 0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 16'h0000, 1, 0, 8'hA5, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 16'h0000, 0, 0, 8'hA5, 0, 1, 0, 0);
        tbl[6]  = mk(0, 0, 16'h0000, 0, 1, 8'h5A, 0, 1, 0, 0);
        tbl[7]  = mk(0, 1, 16'h0102, 1, 0, 8'h5A, 0, 1, 0, 0);
        tbl[8]  = mk(0, 1, 16'h0304, 1, 0, 8'h5A, 1, 0, 0, 0);
        tbl[9]  = mk(0, 0, 16'h0000, 0, 0, 8'h5A, 2, 0, 0, 0);
        tbl[10] = mk(0, 0, 16'h0000, 0, 0, 8'h5A, 2, 0, 0, 0);
        tbl[11] = mk(0, 0, 16'h0000, 0, 1, 8'h01, 1, 0, 0, 0);
        tbl[12] = mk(0, 0, 16'h0000, 0, 0, 8'h01, 1, 0, 0, 0);
        tbl[13] = mk(0, 0, 16'h0000, 1, 0, 8'h01, 1, 0, 0, 0);
        tbl[14] = mk(0, 0, 16'h0000, 0, 0, 8'h01, 1, 0, 0, 0);
        tbl[15] = mk(0, 0, 16'h0000, 1, 0, 8'h02, 1, 0, 0, 0);
        tbl[16] = mk(0, 0, 16'h0000, 0, 1, 8'h02, 1, 0, 0, 0);
        tbl[17] = mk(0, 0, 16'h0000, 1, 0, 8'h02, 1, 0, 0, 0);
        tbl[18] = mk(0, 0, 16'h0000, 0, 0, 8'h02, 1, 0, 0, 0);
        tbl[19] = mk(0, 0, 16'h0000, 0, 0, 8'h02, 1, 0, 0, 0);
        tbl[20] = mk(0, 0, 16'h0000, 0, 1, 8'h03, 0, 1, 0, 0);
        tbl[21] = mk(1, 0, 16'h0000, 0, 0, 8'h03, 0, 1, 0, 0);
        tbl[22] = mk(0, 0, 16'h0000, 0, 0, 8'h00, 0, 1, 0, 0);

        bus.word_valid = 1'b0;
        bus.word_in    = 16'h0000;
        drive(1'b1, 1'b0, 16'h0000, 1'b0);
        drive(1'b1, 1'b0, 16'h0000, 1'b0);

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].r, tbl[i].wv, tbl[i].wi, tbl[i].b);
            check($sformatf("vec%0d", i),
                  {16'h0, bus.tx_start, bus.tx_data, bus.level, bus.empty, bus.full, bus.overflow},
                  {16'h0, tbl[i].st, tbl[i].d, tbl[i].l, tbl[i].e, tbl[i].f, tbl[i].o});
        end

        // overflow: busy held, ten writes, word 9 dropped
        reset_dut();
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 16'(i), 1'b1);
            if (i == 9) check("ovf_full_before", {bus.full, bus.level}, {1'b1, 4'd8});
        end
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check("ovf_pulse", {bus.overflow, bus.level, bus.full}, {1'b1, 4'd8, 1'b1});
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check("ovf_pulse_end", {bus.overflow, bus.level}, {1'b0, 4'd8});
        check("ovf_no_start_while_busy", cap.size(), 0);
        use_model = 1'b1;
        exp_q.delete();
        for (int i = 0; i <= 8; i++) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'(i));
        end
        expect_bytes("ovf_stream", 600);
        check("ovf_drained", {bus.empty, bus.level}, {1'b1, 4'd0});

        // push at full in the same cycle as a pop
        reset_dut();
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, 16'h0010 + 16'(i), 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        check("paf_start_hi", {bus.tx_start, bus.tx_data}, {1'b1, 8'h00});
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        check("paf_start_lo", {bus.tx_start, bus.tx_data}, {1'b1, 8'h10});
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        drive(1'b0, 1'b1, 16'h0019, 1'b0);
        check("paf_full_at_push", {bus.full, bus.level}, {1'b1, 4'd8});
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check("paf_accepted", {bus.overflow, bus.level, bus.full}, {1'b0, 4'd8, 1'b1});
        cap.delete();
        use_model = 1'b1;
        exp_q.delete();
        for (int i = 1; i <= 9; i++) begin
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h10 + 8'(i));
        end
        expect_bytes("paf_stream", 600);

        // reset in WAIT_LO after the first byte of BEEF
        reset_dut();
        drive(1'b0, 1'b1, 16'hBEEF, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        check("rst_first_byte", {bus.tx_start, bus.tx_data}, {1'b1, 8'hBE});
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        drive(1'b1, 1'b1, 16'hDEAD, 1'b1);
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        check("rst_after", {bus.tx_start, bus.tx_data, bus.level, bus.empty}, {1'b0, 8'h00, 4'd0, 1'b1});
        cap.delete();
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        idle(20);
        check("rst_no_more_starts", cap.size(), 0);
        use_model = 1'b1;
        drive(1'b0, 1'b1, 16'h1234, 1'b0);
        exp_q.delete();
        exp_q.push_back(8'h12);
        exp_q.push_back(8'h34);
        expect_bytes("rst_new_word", 100);

        // busy stuck high after a start
        reset_dut();
        drive(1'b0, 1'b1, 16'hC3D4, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        check("stuck_first", {bus.tx_start, bus.tx_data}, {1'b1, 8'hC3});
        drive(1'b0, 1'b0, 16'h0000, 1'b1);
        idle(30);
        check("stuck_single_start", cap.size(), 1);
        drive(1'b0, 1'b0, 16'h0000, 1'b0);
        exp_q.delete();
        exp_q.push_back(8'hC3);
        exp_q.push_back(8'hD4);
        expect_bytes("stuck_resume", 50);
        check("stuck_empty", {bus.empty, bus.level}, {1'b1, 4'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
